vip_pattern_gen: RTL and testbench
==================================

Name: vip_pattern_gen

Overview:
Synthesizable, parametrised video test-pattern source for the vip_core pipeline. It generalises the bench-only image generator in pixel width, channel count and pattern mode. It drives the same FIFO write bus (fifo_data / fifo_wrreq / fifo_full) into vip_top and exports the frame geometry consumed by the image writer. It adds inter-frame gaps, abort, and moving patterns.

Parameters:
CH_WIDTH, 8, bits per colour channel
CHANNELS, 3, channels per pixel; channel 0 is the most-significant field (R)
DIM_WIDTH, 11, width of the width, height and frame-count fields
CHECK_LOG2, 3, checkerboard square size = 2^CHECK_LOG2 pixels
GAP_CYCLES, 0, idle cycles inserted between frames (0 = back-to-back)
DWIDTH (localparam), CH_WIDTH*CHANNELS, pixel bus width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a sequence; sampled only in IDLE
abort  in  1  stop immediately; return to IDLE
cfg_width  in  DIM_WIDTH  pixels per line
cfg_height  in  DIM_WIDTH  lines per frame
cfg_num_frame  in  DIM_WIDTH  frames per sequence
cfg_mode  in  2  0 solid, 1 ramp, 2 colour bars, 3 checkerboard
cfg_color  in  DWIDTH  colour for solid and checkerboard modes
width  out  DIM_WIDTH  latched cfg_width
height  out  DIM_WIDTH  latched cfg_height
num_frame  out  DIM_WIDTH  latched cfg_num_frame
media_type  out  1  1 = video (num_frame > 1), 0 = still image
fifo_full  in  1  downstream FIFO full
fifo_data  out  DWIDTH  pixel data
fifo_wrreq  out  1  write strobe
busy  out  1  high in RUN or GAP
frame_done  out  1  one-cycle pulse after the last pixel of each frame
seq_done  out  1  one-cycle pulse after the last frame

Behaviour:
- Reset: state IDLE; counters x, y, f, gap = 0; width/height/num_frame/media_type/busy/frame_done/seq_done = 0; fifo_wrreq = 0; fifo_data = 0.
- States: IDLE, RUN, GAP.
- IDLE:
  - On start with all three cfg dimensions nonzero: latch every cfg_* input, clear counters, enter RUN on the next cycle.
  - On start with any dimension zero: stay in IDLE; no pulses.
- RUN:
  - fifo_wrreq = (state==RUN) && !fifo_full, combinational. A pixel is accepted on every cycle in which fifo_wrreq is high.
  - fifo_data is a combinational function of the latched config and x, y, f. It is held stable while fifo_full stalls; it is 0 outside RUN.
  - x increments on each accept. At x = width-1: x wraps to 0 and y increments.
  - At y = height-1 with x = width-1: y wraps to 0, f increments, and frame_done pulses on the next cycle.
- End of frame:
  - If that was the last frame (f = num_frame-1): seq_done pulses together with frame_done, and the state goes to IDLE.
  - Else, if GAP_CYCLES > 0: go to GAP.
  - Else: stay in RUN; the first pixel of the next frame is offered the very next cycle.
- GAP: count GAP_CYCLES cycles with fifo_wrreq = 0, then return to RUN.
- abort: has priority over everything. On the next cycle the state is IDLE and the counters are cleared; no frame_done or seq_done pulses; the latched geometry outputs are kept.
- start while busy is ignored. abort in IDLE has no effect.
- Patterns (x, y, f are the current counters):
  - mode 0 (solid): cfg_color.
  - mode 1 (ramp): every channel = (x + f) truncated to CH_WIDTH.
  - mode 2 (colour bars):
    - bar_len = width>>3, with a minimum of 1. A bar counter advances every bar_len pixels, resets at each line start and saturates at 7.
    - Bar i gives R = ~i[1], G = ~i[2], B = ~i[0], giving white, yellow, cyan, green, magenta, red, blue, black.
    - Channel c uses the rule for c mod 3; each channel is all-ones or zero.
  - mode 3 (checkerboard): cfg_color when bit CHECK_LOG2 of x XOR bit CHECK_LOG2 of y XOR f[0] is 1, else 0.
- Counters are DIM_WIDTH bits wide; widths up to 2^DIM_WIDTH-1 are legal without overflow.

Decomposition:
- Package vip_pkg: mode encodings (MODE_SOLID, MODE_RAMP, MODE_BARS, MODE_CHECK), state encodings, and the bar colour rule as a function.
- One sub-module, vip_pattern_pixel: combinational pattern generator taking mode, x, y, f, bar index and cfg_color, returning the pixel.
- FSM, counters and FIFO handshake stay in vip_pattern_gen.

Test Plan:
- Reset/idle: assert reset → all outputs 0. Then start with cfg_width = 0 → remains IDLE, busy = 0, no fifo_wrreq.
- Solid mode: width 4, height 2, 1 frame, cfg_color 24'h123456, fifo_full = 0 → 8 consecutive writes of 24'h123456; frame_done and seq_done pulse together one cycle after the last write; media_type = 0.
- Backpressure: ramp mode, width 8, height 1; fifo_full high for 3 cycles during pixel 3 → fifo_wrreq = 0 for those cycles, fifo_data held at 24'h030303, then data continues 04..07 with no loss or duplication.
- Colour bars: width 16, height 1 → pixel pairs FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Also width 20 → bar_len = 2, last 4 pixels 000000 (saturated at bar 7).
- Checkerboard, multi-frame with gap: width 16, height 16, 2 frames, GAP_CYCLES = 5, CHECK_LOG2 = 3 → pixel (0,0) is 0 in frame 0 and cfg_color in frame 1; exactly 5 idle cycles between frames; frame_done pulses twice, seq_done once; media_type = 1.
- Abort and busy start: abort mid-frame at pixel 10 → next cycle IDLE, fifo_wrreq = 0, no done pulses. A start issued during RUN is ignored and the pixel sequence is unaffected.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared encodings and helpers for the vip_pattern_gen test-pattern source.
package vip_pkg;

   // Pattern selector carried on cfg_mode
   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_BARS  = 2'd2,
      MODE_CHECK = 2'd3
   } mode_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Index of the final colour bar; the bar counter saturates here
   localparam logic [2:0] BAR_LAST = 3'd7;

   // Bar i -> {R,G,B} on/off; walks white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
      return {~bar[1], ~bar[2], ~bar[0]};
   endfunction

endpackage

// File: rtl/vip_pattern_gen_if.sv
// FIFO write bus between the pattern source (master) and the downstream FIFO (slave).
interface vip_pattern_gen_if #(
   parameter int DWIDTH = 24
);
   logic [DWIDTH-1:0] fifo_data;
   logic              fifo_wrreq;
   logic              fifo_full;

   modport master (output fifo_data, output fifo_wrreq, input fifo_full);
   modport slave  (input fifo_data, input fifo_wrreq, output fifo_full);
endinterface

// File: rtl/vip_pattern_pixel.sv
// Combinational pixel generator: maps the current (x, y, f) position, bar index
// and latched configuration to one packed pixel. Channel 0 is the MS field.
module vip_pattern_pixel
   import vip_pkg::*;
#(
   parameter int  CH_WIDTH   = 8,
   parameter int  CHANNELS   = 3,
   parameter int  DIM_WIDTH  = 11,
   parameter int  CHECK_LOG2 = 3,
   localparam int DWIDTH     = CH_WIDTH * CHANNELS
) (
   input  mode_e                mode,
   input  logic [DIM_WIDTH-1:0] x,
   input  logic [DIM_WIDTH-1:0] y,
   input  logic [DIM_WIDTH-1:0] f,
   input  logic [2:0]           bar,
   input  logic [DWIDTH-1:0]    color,
   output logic [DWIDTH-1:0]    pixel
);

   logic [DIM_WIDTH-1:0] w_sum;
   logic [2:0]           w_rgb;
   logic                 w_check;
   logic                 w_unused_y;

   // Ramp advances one code per pixel and shifts by one code per frame
   assign w_sum      = x + f;
   assign w_rgb      = bar_rgb(bar);
   // Squares flip polarity on alternate frames so the board appears to move
   assign w_check    = x[CHECK_LOG2] ^ y[CHECK_LOG2] ^ f[0];
   // Only one bit of y selects the square row; the rest is intentionally ignored
   assign w_unused_y = ^y;

   // Select the pattern and replicate per-channel values across the pixel
   always_comb begin
      pixel = '0;
      case (mode)
         MODE_SOLID: pixel = color;
         MODE_RAMP: begin
            for (int c = 0; c < CHANNELS; c++)
               pixel[(CHANNELS-1-c)*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'(w_sum);
         end
         MODE_BARS: begin
            for (int c = 0; c < CHANNELS; c++)
               pixel[(CHANNELS-1-c)*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{w_rgb[2 - (c % 3)]}};
         end
         MODE_CHECK: pixel = w_check ? color : '0;
         default:    pixel = '0;
      endcase
   end

endmodule

// File: rtl/vip_pattern_gen.sv
// Parametrised video test-pattern source. Sequences x/y/frame counters over a
// latched geometry, writes pixels into the downstream FIFO with full-flag
// backpressure, optionally idles between frames, and supports abort.
module vip_pattern_gen
   import vip_pkg::*;
#(
   parameter int  CH_WIDTH   = 8,
   parameter int  CHANNELS   = 3,
   parameter int  DIM_WIDTH  = 11,
   parameter int  CHECK_LOG2 = 3,
   parameter int  GAP_CYCLES = 0,
   localparam int DWIDTH     = CH_WIDTH * CHANNELS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DIM_WIDTH-1:0] cfg_width,
   input  logic [DIM_WIDTH-1:0] cfg_height,
   input  logic [DIM_WIDTH-1:0] cfg_num_frame,
   input  logic [1:0]           cfg_mode,
   input  logic [DWIDTH-1:0]    cfg_color,
   output logic [DIM_WIDTH-1:0] width,
   output logic [DIM_WIDTH-1:0] height,
   output logic [DIM_WIDTH-1:0] num_frame,
   output logic                 media_type,
   vip_pattern_gen_if.master    fifo,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 seq_done
);

   localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Control state
   state_e               r_state;
   logic [DIM_WIDTH-1:0] r_x;
   logic [DIM_WIDTH-1:0] r_y;
   logic [DIM_WIDTH-1:0] r_f;
   logic [GAP_W-1:0]     r_gap;
   logic [2:0]           r_bar;
   logic [DIM_WIDTH-1:0] r_bar_cnt;
   logic [DIM_WIDTH-1:0] r_width;
   logic [DIM_WIDTH-1:0] r_height;
   logic [DIM_WIDTH-1:0] r_num_frame;
   logic                 r_media;
   logic                 r_frame_done;
   logic                 r_seq_done;

   // Latched pattern configuration (no reset needed: only observed in RUN)
   mode_e                r_mode;
   logic [DWIDTH-1:0]    r_color;
   logic [DIM_WIDTH-1:0] r_bar_len;

   logic                 w_cfg_ok;
   logic                 w_launch;
   logic                 w_accept;
   logic                 w_last_x;
   logic                 w_last_y;
   logic                 w_last_f;
   logic                 w_bar_step;
   logic [DIM_WIDTH-1:0] w_cfg_bar_len;
   logic [DWIDTH-1:0]    w_pixel;

   assign w_cfg_ok      = (|cfg_width) && (|cfg_height) && (|cfg_num_frame);
   assign w_launch      = (r_state == ST_IDLE) && start && w_cfg_ok && !abort;
   // Eight bars per line; very narrow lines still get one pixel per bar
   assign w_cfg_bar_len = ((cfg_width >> 3) == '0) ? DIM_WIDTH'(1) : (cfg_width >> 3);

   assign w_accept   = fifo.fifo_wrreq;
   assign w_last_x   = (r_x == r_width - DIM_WIDTH'(1));
   assign w_last_y   = (r_y == r_height - DIM_WIDTH'(1));
   assign w_last_f   = (r_f == r_num_frame - DIM_WIDTH'(1));
   assign w_bar_step = (r_bar_cnt == r_bar_len - DIM_WIDTH'(1));

   // Write strobe is purely combinational so a full flag stalls in the same cycle
   assign fifo.fifo_wrreq = (r_state == ST_RUN) && !fifo.fifo_full;
   assign fifo.fifo_data  = (r_state == ST_RUN) ? w_pixel : '0;

   assign width      = r_width;
   assign height     = r_height;
   assign num_frame  = r_num_frame;
   assign media_type = r_media;
   assign busy       = (r_state != ST_IDLE);
   assign frame_done = r_frame_done;
   assign seq_done   = r_seq_done;

   vip_pattern_pixel #(
      .CH_WIDTH   (CH_WIDTH),
      .CHANNELS   (CHANNELS),
      .DIM_WIDTH  (DIM_WIDTH),
      .CHECK_LOG2 (CHECK_LOG2)
   ) u_pixel (
      .mode  (r_mode),
      .x     (r_x),
      .y     (r_y),
      .f     (r_f),
      .bar   (r_bar),
      .color (r_color),
      .pixel (w_pixel)
   );

   // Capture pattern selection and bar length when a sequence is launched
   always_ff @(posedge clock) begin
      if (w_launch) begin
         r_mode    <= mode_e'(cfg_mode);
         r_color   <= cfg_color;
         r_bar_len <= w_cfg_bar_len;
      end
   end

   // Sequencer: state, raster counters, geometry latch and done pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_f          <= '0;
         r_gap        <= '0;
         r_bar        <= '0;
         r_bar_cnt    <= '0;
         r_width      <= '0;
         r_height     <= '0;
         r_num_frame  <= '0;
         r_media      <= 1'b0;
         r_frame_done <= 1'b0;
         r_seq_done   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_seq_done   <= 1'b0;
         if (abort) begin
            // Abort wins over everything; geometry outputs are left as they were
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_f       <= '0;
            r_gap     <= '0;
            r_bar     <= '0;
            r_bar_cnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start && w_cfg_ok) begin
                     r_width     <= cfg_width;
                     r_height    <= cfg_height;
                     r_num_frame <= cfg_num_frame;
                     r_media     <= (cfg_num_frame > DIM_WIDTH'(1));
                     r_x         <= '0;
                     r_y         <= '0;
                     r_f         <= '0;
                     r_gap       <= '0;
                     r_bar       <= '0;
                     r_bar_cnt   <= '0;
                     r_state     <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (w_accept) begin
                     if (w_last_x) begin
                        r_x       <= '0;
                        r_bar     <= '0;
                        r_bar_cnt <= '0;
                        if (w_last_y) begin
                           r_y          <= '0;
                           r_frame_done <= 1'b1;
                           if (w_last_f) begin
                              r_seq_done <= 1'b1;
                              r_f        <= '0;
                              r_state    <= ST_IDLE;
                           end else begin
                              r_f <= r_f + DIM_WIDTH'(1);
                              if (GAP_CYCLES > 0) begin
                                 r_gap   <= '0;
                                 r_state <= ST_GAP;
                              end
                           end
                        end else begin
                           r_y <= r_y + DIM_WIDTH'(1);
                        end
                     end else begin
                        r_x <= r_x + DIM_WIDTH'(1);
                        if (w_bar_step) begin
                           r_bar_cnt <= '0;
                           if (r_bar != BAR_LAST)
                              r_bar <= r_bar + 3'd1;
                        end else begin
                           r_bar_cnt <= r_bar_cnt + DIM_WIDTH'(1);
                        end
                     end
                  end
               end
               ST_GAP: begin
                  if (r_gap == GAP_LAST) begin
                     r_gap   <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_gap <= r_gap + GAP_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Scoreboard bench for vip_pattern_gen: expected pixels are queued when a
// sequence is launched and popped by a monitor on every observed write.
module tb_vip_pattern_gen;

   localparam int DW = 24;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [10:0]   cfg_width;
   logic [10:0]   cfg_height;
   logic [10:0]   cfg_num_frame;
   logic [1:0]    cfg_mode;
   logic [DW-1:0] cfg_color;
   logic [10:0]   width;
   logic [10:0]   height;
   logic [10:0]   num_frame;
   logic          media_type;
   logic          busy;
   logic          frame_done;
   logic          seq_done;

   vip_pattern_gen_if #(.DWIDTH(DW)) fifo_bus ();

   vip_pattern_gen #(
      .CH_WIDTH   (8),
      .CHANNELS   (3),
      .DIM_WIDTH  (11),
      .CHECK_LOG2 (3),
      .GAP_CYCLES (5)
   ) dut (
      .clock         (clk),
      .reset         (rst),
      .start         (start),
      .abort         (abort),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .cfg_num_frame (cfg_num_frame),
      .cfg_mode      (cfg_mode),
      .cfg_color     (cfg_color),
      .width         (width),
      .height        (height),
      .num_frame     (num_frame),
      .media_type    (media_type),
      .fifo          (fifo_bus),
      .busy          (busy),
      .frame_done    (frame_done),
      .seq_done      (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            fd_cnt = 0;
   int            sd_cnt = 0;
   int            fd_cyc = -1;
   int            sd_cyc = -1;
   logic [DW-1:0] exp_q[$];
   int            wr_cyc[$];

   // Reference pixel, written directly from the pattern definitions
   function automatic logic [DW-1:0] model_pix(input int mode, input int x, input int y,
                                               input int f, input int w, input logic [DW-1:0] color);
      int         bl;
      int         bi;
      logic [7:0] r;
      case (mode)
         0: return color;
         1: begin
            r = 8'((x + f) & 255);
            return {r, r, r};
         end
         2: begin
            bl = w >> 3;
            if (bl == 0) bl = 1;
            bi = x / bl;
            if (bi > 7) bi = 7;
            case (bi)
               0:       return 24'hFFFFFF;
               1:       return 24'hFFFF00;
               2:       return 24'h00FFFF;
               3:       return 24'h00FF00;
               4:       return 24'hFF00FF;
               5:       return 24'hFF0000;
               6:       return 24'h0000FF;
               default: return 24'h000000;
            endcase
         end
         default: return ((((x >> 3) ^ (y >> 3) ^ f) & 1) != 0) ? color : 24'h0;
      endcase
   endfunction

   task automatic push_seq(input int mode, input int w, input int h, input int nf,
                           input logic [DW-1:0] color);
      for (int f = 0; f < nf; f++)
         for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
               exp_q.push_back(model_pix(mode, x, y, f, w, color));
   endtask

   task automatic clear_stats();
      fd_cnt = 0;
      sd_cnt = 0;
      fd_cyc = -1;
      sd_cyc = -1;
      wr_cyc.delete();
      exp_q.delete();
   endtask

   // Returns one cycle after the edge that samples start
   task automatic do_start(input int mode, input int w, input int h, input int nf,
                           input logic [DW-1:0] color);
      @(posedge clk); #1;
      cfg_mode      = 2'(mode);
      cfg_width     = 11'(w);
      cfg_height    = 11'(h);
      cfg_num_frame = 11'(nf);
      cfg_color     = color;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every write and records pulse timing
   always @(negedge clk) begin
      logic [DW-1:0] e;
      cyc++;
      if (fifo_bus.fifo_wrreq === 1'b1) begin
         wr_cyc.push_back(cyc);
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got data %h, required no write", fifo_bus.fifo_data);
         end else begin
            e = exp_q.pop_front();
            if (fifo_bus.fifo_data !== e) begin
               n_err++;
               $display("FAIL pixel_data @cyc %0d: got %h, required %h", cyc, fifo_bus.fifo_data, e);
            end
         end
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         fd_cyc = cyc;
      end
      if (seq_done === 1'b1) begin
         sd_cnt++;
         sd_cyc = cyc;
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_bus.fifo_full = 1'b0;
      cfg_width = '0; cfg_height = '0; cfg_num_frame = '0; cfg_mode = '0; cfg_color = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({width, height, num_frame} !== 33'h0) begin
         n_err++;
         $display("FAIL reset_geometry: got %h/%h/%h, required 0", width, height, num_frame);
      end
      n_vec++;
      if ({media_type, busy, frame_done, seq_done, fifo_bus.fifo_wrreq, fifo_bus.fifo_data} !== 29'h0) begin
         n_err++;
         $display("FAIL reset_ctrl: got mt=%b busy=%b fd=%b sd=%b wr=%b data=%h, required all 0",
                  media_type, busy, frame_done, seq_done, fifo_bus.fifo_wrreq, fifo_bus.fifo_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_stats();
      do_start(0, 0, 4, 1, 24'h111111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (busy !== 1'b0 || fifo_bus.fifo_wrreq !== 1'b0) begin
            n_err++;
            $display("FAIL zero_dim_start: got busy=%b wr=%b, required 0/0", busy, fifo_bus.fifo_wrreq);
         end
      end
      n_vec++;
      if (fd_cnt != 0 || sd_cnt != 0) begin
         n_err++;
         $display("FAIL zero_dim_pulses: got fd=%0d sd=%0d, required 0/0", fd_cnt, sd_cnt);
      end
   endtask

   task automatic test_solid();
      clear_stats();
      push_seq(0, 4, 2, 1, 24'h123456);
      do_start(0, 4, 2, 1, 24'h123456);
      for (int i = 0; i < 50 && sd_cnt == 0; i++) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (sd_cnt != 1 || fd_cnt != 1) begin
         n_err++;
         $display("FAIL solid_pulses: got fd=%0d sd=%0d, required 1/1", fd_cnt, sd_cnt);
      end
      n_vec++;
      if (wr_cyc.size() != 8) begin
         n_err++;
         $display("FAIL solid_count: got %0d writes, required 8", wr_cyc.size());
      end else begin
         n_vec++;
         if (wr_cyc[7] - wr_cyc[0] != 7) begin
            n_err++;
            $display("FAIL solid_contiguous: got span %0d, required 7", wr_cyc[7] - wr_cyc[0]);
         end
         n_vec++;
         if (fd_cyc != wr_cyc[7] + 1 || sd_cyc != fd_cyc) begin
            n_err++;
            $display("FAIL solid_done_timing: got fd@%0d sd@%0d, required both @%0d",
                     fd_cyc, sd_cyc, wr_cyc[7] + 1);
         end
      end
      n_vec++;
      if (media_type !== 1'b0 || width !== 11'd4 || height !== 11'd2 || num_frame !== 11'd1) begin
         n_err++;
         $display("FAIL solid_geometry: got mt=%b %0d x %0d x %0d, required 0 4x2x1",
                  media_type, width, height, num_frame);
      end
      n_vec++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL solid_end: got busy=%b pending=%0d, required 0/0", busy, exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      clear_stats();
      push_seq(1, 8, 1, 1, 24'h0);
      do_start(1, 8, 1, 1, 24'h0);
      repeat (3) @(posedge clk);
      #1;
      fifo_bus.fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (fifo_bus.fifo_wrreq !== 1'b0 || fifo_bus.fifo_data !== 24'h030303) begin
            n_err++;
            $display("FAIL stall_hold: got wr=%b data=%h, required 0 030303",
                     fifo_bus.fifo_wrreq, fifo_bus.fifo_data);
         end
         @(posedge clk);
      end
      #1;
      fifo_bus.fifo_full = 1'b0;
      for (int i = 0; i < 50 && sd_cnt == 0; i++) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (wr_cyc.size() != 8 || exp_q.size() != 0 || sd_cnt != 1) begin
         n_err++;
         $display("FAIL stall_total: got writes=%0d pending=%0d sd=%0d, required 8/0/1",
                  wr_cyc.size(), exp_q.size(), sd_cnt);
      end
   endtask

   task automatic test_bars();
      for (int k = 0; k < 2; k++) begin
         clear_stats();
         push_seq(2, (k == 0) ? 16 : 20, 1, 1, 24'h0);
         do_start(2, (k == 0) ? 16 : 20, 1, 1, 24'h0);
         for (int i = 0; i < 60 && sd_cnt == 0; i++) @(posedge clk);
         @(negedge clk);
         n_vec++;
         if (sd_cnt != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bars_%0d_end: got sd=%0d pending=%0d, required 1/0", k, sd_cnt, exp_q.size());
         end
      end
   endtask

   task automatic test_checker_gap();
      clear_stats();
      push_seq(3, 16, 16, 2, 24'hA5C3E1);
      do_start(3, 16, 16, 2, 24'hA5C3E1);
      for (int i = 0; i < 1000 && sd_cnt == 0; i++) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (fd_cnt != 2 || sd_cnt != 1) begin
         n_err++;
         $display("FAIL check_pulses: got fd=%0d sd=%0d, required 2/1", fd_cnt, sd_cnt);
      end
      n_vec++;
      if (media_type !== 1'b1) begin
         n_err++;
         $display("FAIL check_media: got %b, required 1", media_type);
      end
      n_vec++;
      if (wr_cyc.size() != 512) begin
         n_err++;
         $display("FAIL check_count: got %0d writes, required 512", wr_cyc.size());
      end else begin
         n_vec++;
         if (wr_cyc[256] - wr_cyc[255] - 1 != 5) begin
            n_err++;
            $display("FAIL check_gap: got %0d idle cycles, required 5", wr_cyc[256] - wr_cyc[255] - 1);
         end
         n_vec++;
         if (wr_cyc[255] - wr_cyc[0] != 255) begin
            n_err++;
            $display("FAIL check_frame0_contig: got span %0d, required 255", wr_cyc[255] - wr_cyc[0]);
         end
      end
   endtask

   task automatic test_abort_busy_start();
      clear_stats();
      for (int x = 0; x <= 10; x++) exp_q.push_back(model_pix(1, x, 0, 0, 16, 24'h0));
      do_start(1, 16, 2, 1, 24'h0);
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; cfg_mode = 2'd0; cfg_width = 11'd4; cfg_color = 24'hFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_vec++;
      if (fifo_bus.fifo_wrreq !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_idle: got wr=%b busy=%b, required 0/0", fifo_bus.fifo_wrreq, busy);
      end
      n_vec++;
      if (width !== 11'd16 || height !== 11'd2) begin
         n_err++;
         $display("FAIL abort_geometry: got %0d x %0d, required 16 x 2", width, height);
      end
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (fd_cnt != 0 || sd_cnt != 0 || wr_cyc.size() != 11 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL abort_stream: got fd=%0d sd=%0d writes=%0d pending=%0d, required 0/0/11/0",
                  fd_cnt, sd_cnt, wr_cyc.size(), exp_q.size());
      end
      // A fresh run after abort must start again from pixel 0
      clear_stats();
      push_seq(1, 4, 1, 1, 24'h0);
      do_start(1, 4, 1, 1, 24'h0);
      for (int i = 0; i < 40 && sd_cnt == 0; i++) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (sd_cnt != 1 || exp_q.size() != 0 || wr_cyc.size() != 4) begin
         n_err++;
         $display("FAIL restart_after_abort: got sd=%0d pending=%0d writes=%0d, required 1/0/4",
                  sd_cnt, exp_q.size(), wr_cyc.size());
      end
   endtask

   initial begin
      test_reset();
      test_solid();
      test_backpressure();
      test_bars();
      test_checker_gap();
      test_abort_busy_start();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
